// File: rtl/dot_product_engine.sv
// dot_product_engine: reads paired operands from two registered-output
// memories at a shared address and accumulates their unsigned products.
// The final sum is presented together with a one-cycle done pulse.
module dot_product_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ACC_WIDTH  = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   vec_len,
    output logic                  read_en,
    output logic [ADDR_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_WIDTH-1:0]  result
);

    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  ren_q, ren_d;
    logic                  vld_p1_q, vld_p1_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [ACC_WIDTH-1:0]  result_q, result_d;

    logic [LEN_W-1:0]      len_clamped;
    logic [LEN_W-1:0]      last_idx;
    logic [LEN_W-1:0]      addr_ext;

    // Unsigned full-width product, zero-extended into the accumulator width.
    function automatic logic [ACC_WIDTH-1:0] prod_ext(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [2*DATA_WIDTH-1:0] p;
        p = a * b;
        return ACC_WIDTH'(p);
    endfunction

    assign len_clamped = (vec_len > MAX_LEN) ? MAX_LEN : vec_len;
    assign last_idx    = len_q - LEN_W'(1);
    assign addr_ext    = {1'b0, addr_q};

    // Next-state, address issue, valid tracking and accumulation.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        addr_d   = addr_q;
        ren_d    = ren_q;
        // Stage p0 is the issued read (ren_q); stage p1 marks memory data on the bus.
        vld_p1_d = ren_q;
        acc_d    = acc_q;
        result_d = result_q;

        if (vld_p1_q) begin
            acc_d = acc_q + prod_ext(a_data, b_data);
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d = len_clamped;
                    acc_d = '0;
                    if (len_clamped == '0) begin
                        state_d  = S_DONE;
                        result_d = '0;
                    end else begin
                        state_d = S_READ;
                        ren_d   = 1'b1;
                        addr_d  = '0;
                    end
                end
            end
            S_READ: begin
                if (addr_ext == last_idx) begin
                    // Single-element vector: its only address is already out.
                    ren_d   = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (addr_ext + LEN_W'(1) == last_idx) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                ren_d = 1'b0;
                // Last element is on the bus once no read is outstanding behind it.
                if (!ren_q && vld_p1_q) begin
                    state_d  = S_DONE;
                    result_d = acc_d;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            addr_q   <= '0;
            ren_q    <= 1'b0;
            vld_p1_q <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            ren_q    <= ren_d;
            vld_p1_q <= vld_p1_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign read_en      = ren_q;
    assign read_address = addr_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign result       = result_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed testbench for dot_product_engine with two registered-read memory models.
module tb_dot_product_engine;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  vec_len;
    logic        read_en;
    logic [3:0]  read_address;
    logic [7:0]  a_data;
    logic [7:0]  b_data;
    logic        busy;
    logic        done;
    logic [19:0] result;

    logic [7:0]  mem_a [16];
    logic [7:0]  mem_b [16];

    int          n_checks;
    int          n_pass;

    dot_product_engine #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .ACC_WIDTH (20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .vec_len     (vec_len),
        .read_en     (read_en),
        .read_address(read_address),
        .a_data      (a_data),
        .b_data      (b_data),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models with one-cycle registered read latency.
    always @(posedge clk) begin
        if (read_en) begin
            a_data <= mem_a[read_address];
            b_data <= mem_b[read_address];
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one computation; ign_at >= 0 pulses a second start (vec_len=2) that must be ignored.
    task automatic run_vec(input string name, input int len, input int exp_res,
                           input int exp_reads, input int exp_lat, input int ign_at);
        int addr_log[$];
        int n;
        vec_len = 5'(len);
        start   = 1'b1;
        tick();                       // edge E0
        start   = 1'b0;
        n       = 0;
        while (done !== 1'b1 && n < 60) begin
            if (read_en === 1'b1) addr_log.push_back(int'(read_address));
            if (n == ign_at) begin
                start   = 1'b1;
                vec_len = 5'd2;
            end
            tick();
            start = 1'b0;
            n++;
        end
        check_val({name, "_latency"}, n, exp_lat);
        check_val({name, "_result"}, int'(result), exp_res);
        check_val({name, "_busy_at_done"}, int'(busy), 1);
        check_val({name, "_reads"}, addr_log.size(), exp_reads);
        for (int i = 0; i < addr_log.size(); i++) begin
            check_val({name, "_addr"}, addr_log[i], i);
        end
        tick();
        check_val({name, "_done_pulse"}, int'(done), 0);
        check_val({name, "_busy_after"}, int'(busy), 0);
        check_val({name, "_result_hold"}, int'(result), exp_res);
    endtask

    initial begin
        int done_seen;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        vec_len  = '0;
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'd0;
            mem_b[i] = 8'd0;
        end
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = 8'(i + 1);
            mem_b[i] = 8'(i + 5);
        end

        tick();
        tick();
        check_val("rst_read_en", int'(read_en), 0);
        check_val("rst_addr", int'(read_address), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_result", int'(result), 0);
        rst_n = 1'b1;
        tick();

        // 1*5 + 2*6 + 3*7 + 4*8 = 70
        run_vec("len4", 4, 70, 4, 5, -1);
        run_vec("len0", 0, 0, 0, 0, -1);

        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'hFF;
            mem_b[i] = 8'hFF;
        end
        // 16 * 255 * 255 = 1040400
        run_vec("len16", 16, 1040400, 16, 17, -1);
        run_vec("len20_clamp", 20, 1040400, 16, 17, -1);

        for (int i = 0; i < 16; i++) begin
            mem_a[i] = (i < 4) ? 8'(i + 1) : 8'd9;
            mem_b[i] = (i < 4) ? 8'(i + 5) : 8'd9;
        end
        run_vec("len4_ign", 4, 70, 4, 5, 2);
        // 1*5 + 2*6 = 17
        run_vec("len2", 2, 17, 2, 3, -1);

        // Reset in the middle of a length-8 run.
        vec_len = 5'd8;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_val("midrst_read_en", int'(read_en), 0);
        check_val("midrst_addr", int'(read_address), 0);
        check_val("midrst_busy", int'(busy), 0);
        check_val("midrst_done", int'(done), 0);
        check_val("midrst_result", int'(result), 0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check_val("midrst_no_done", done_seen, 0);
        run_vec("after_rst", 4, 70, 4, 5, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
